ez8_prog_loader: RTL and testbench
==================================

EZ8_PROG_LOADER -- requirements
Module: ez8_prog_loader

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset, named clk and reset, listed first below.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_data  input  8  byte stream from host link.
REQ-005 Port: in_valid  input  1  in_data valid this cycle.
REQ-006 Port: in_ready  output  1  block accepts a byte; transfer occurs when in_valid && in_ready.
REQ-007 Port: instr_writeaddr  output  12  instruction-memory word address.
REQ-008 Port: instr_writedata  output  16  instruction word.
REQ-009 Port: instr_write_en  output  1  one-cycle write strobe.
REQ-010 Port: cpu_reset  output  1  holds ez8_cpu in reset while not RUN.
REQ-011 Port: loading  output  1  high in LEN_HI through CSUM.
REQ-012 Port: done  output  1  high in RUN.
REQ-013 Port: error  output  1  high in ERROR.

Function
REQ-014 States SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, RUN, ERROR.
REQ-015 in_ready SHALL be 1 in every state; bytes are consumed one per accepted transfer.
REQ-016 IDLE/RUN/ERROR: accepted byte 0xA5 -> LEN_HI, cpu_reset=1 next cycle; any other byte dropped, state unchanged.
REQ-017 LEN_HI latches len[11:8]=in_data[3:0] (bits 7:4 ignored); LEN_LO latches len[7:0]; len==0 -> ERROR, else DATA_HI with word index cleared to 0.
REQ-018 DATA_HI latches high byte; DATA_LO forms word {hi,lo} -> next state DATA_HI, or CSUM/RUN after the len-th word.
REQ-019 instr_write_en SHALL pulse for exactly the cycle after the DATA_LO byte is accepted, with instr_writeaddr=word index and instr_writedata={hi,lo}; index then increments.
REQ-020 Word index is 12 bits; len=4096 is unrepresentable, max len=4095, no address wrap.
REQ-021 Running checksum = 8-bit modulo-256 sum of all data bytes, cleared on entry to LEN_HI.
REQ-022 CSUM: accepted byte equal to checksum -> RUN; otherwise -> ERROR.
REQ-023 cpu_reset SHALL be 0 only in RUN; deasserts the cycle RUN is entered.
REQ-024 No write strobe SHALL occur outside DATA_LO completion; idle cycles (in_valid=0) mid-frame hold state indefinitely.
REQ-025 0xA5 received mid-frame SHALL be treated as data/length, not resync.

Reset
REQ-026 reset SHALL force IDLE, cpu_reset=1, instr_write_en=0, instr_writeaddr=0, instr_writedata=0, loading=0, done=0, error=0, checksum=0, index=0.
REQ-027 reset mid-frame SHALL abort the frame; previously written words remain in memory; no write strobe in the reset cycle or after.

Configuration
REQ-028 Macro PROG_LOADER_CHECKSUM_EN defined: CSUM state and checksum logic present per REQ-021/022.
REQ-029 Macro PROG_LOADER_CHECKSUM_EN undefined: no CSUM state, no checksum byte; last DATA_LO transfer -> RUN directly.

Verification
REQ-030 Frame A5,00,02,12,34,AB,CD,BE -> writes (0,0x1234),(1,0xABCD), then done=1, cpu_reset=0.
REQ-031 Same frame with checksum 0xBF -> both writes occur, then error=1, cpu_reset=1; subsequent A5,00,01,00,07,07 -> write (0,0x0007), done=1.
REQ-032 Frame A5,F0,00 -> ERROR (masked len=0), no write strobes.
REQ-033 Frame A5,00,01,12 with in_valid gaps of 5 cycles between bytes, reset before final byte -> IDLE, cpu_reset=1, no write strobe.
REQ-034 In RUN, bytes 0x00,0x55 -> ignored, done stays 1; byte 0xA5 -> loading=1, cpu_reset=1 next cycle.
REQ-035 Without PROG_LOADER_CHECKSUM_EN: A5,00,01,BE,EF -> write (0,0xBEEF), RUN the cycle after last byte.

Source files
------------

// File: rtl/ez8_prog_loader.sv
// ez8_prog_loader: receives a framed program image over a byte stream and
// writes it word by word into ez8 instruction memory, holding the CPU in
// reset until a complete (and, optionally, checksum-verified) image is loaded.
// Frame: A5, len_hi (low nibble used), len_lo, len x {hi, lo} [, checksum].
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds the trailing checksum
// byte (mod-256 sum of all data bytes) and its CSUM state.
module ez8_prog_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] instr_writeaddr,
  output logic [15:0] instr_writedata,
  output logic        instr_write_en,
  output logic        cpu_reset,
  output logic        loading,
  output logic        done,
  output logic        error
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WORD_W = 16;
  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CSUM    = 3'd5,
`endif
    S_RUN     = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                loading_q, loading_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   csum_q, csum_d;
`endif
  logic                accept;
  logic                last_word;

  // The loader never back-pressures the host link.
  assign in_ready  = 1'b1;
  assign accept    = in_valid & in_ready;
  // len is never 0 in the data states, so len-1 cannot underflow there.
  assign last_word = (idx_q == (len_q - ADDR_W'(1)));

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    unique case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d = S_LEN_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[11:8] = in_data[3:0];
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          idx_d      = '0;
          state_d    = ({len_q[11:8], in_data} == '0) ? S_ERROR : S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = BYTE_W'(csum_q + in_data);
`endif
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = {hi_q, in_data};
          idx_d   = ADDR_W'(idx_q + ADDR_W'(1));
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = BYTE_W'(csum_q + in_data);
          state_d = last_word ? S_CSUM : S_DATA_HI;
`else
          state_d = last_word ? S_RUN : S_DATA_HI;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_RUN : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Status flags follow the state being entered so they change with it.
    cpu_reset_d = (state_d != S_RUN);
    done_d      = (state_d == S_RUN);
    error_d     = (state_d == S_ERROR);
    loading_d   = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                  (state_d == S_DATA_HI) || (state_d == S_DATA_LO)
`ifdef PROG_LOADER_CHECKSUM_EN
                  || (state_d == S_CSUM)
`endif
                  ;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      hi_q        <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      loading_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      loading_q   <= loading_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign instr_writeaddr = waddr_q;
  assign instr_writedata = wdata_q;
  assign instr_write_en  = we_q;
  assign cpu_reset       = cpu_reset_q;
  assign loading         = loading_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_ez8_prog_loader.sv
// Self-checking bench for ez8_prog_loader: directed frames plus randomized
// frames compared against a frame-level expectation (word list + outcome).
module tb_ez8_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] instr_writeaddr;
  logic [15:0] instr_writedata;
  logic        instr_write_en;
  logic        cpu_reset;
  logic        loading;
  logic        done;
  logic        error;

  int n_assert = 0;
  int n_fail   = 0;

  logic [27:0] got[$];
  logic [15:0] fw[$];

  ez8_prog_loader dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instr_writeaddr (instr_writeaddr),
    .instr_writedata (instr_writedata),
    .instr_write_en  (instr_write_en),
    .cpu_reset       (cpu_reset),
    .loading         (loading),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  // Record every cycle the write strobe is high.
  always @(posedge clk) begin
    if (instr_write_en) got.push_back({instr_writeaddr, instr_writedata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; byte transfers on the rising edge between.
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_we"},        32'(instr_write_en), 32'd0);
    chk({tag, "_addr"},      32'(instr_writeaddr), 32'd0);
    chk({tag, "_data"},      32'(instr_writedata), 32'd0);
    chk({tag, "_loading"},   32'(loading), 32'd0);
    chk({tag, "_done"},      32'(done), 32'd0);
    chk({tag, "_error"},     32'(error), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready), 32'd1);
  endtask

  // Sends one frame built from fw[0:len-1]; expectation derived from frame contents.
  task automatic run_frame(input string tag, input int unsigned len, input logic [3:0] junk,
                           input bit bad_cs, input int gapmax);
    logic [7:0] sum;
    logic [15:0] w;
    bit exp_ok;
    int exp_n;
    sum = 8'h00;
    got.delete();
    send(8'hA5, $urandom_range(0, gapmax));
    chk({tag, "_sync_loading"}, 32'(loading), 32'd1);
    chk({tag, "_sync_cpurst"},  32'(cpu_reset), 32'd1);
    chk({tag, "_sync_done"},    32'(done), 32'd0);
    send({junk, 4'(len >> 8)}, $urandom_range(0, gapmax));
    send(8'(len), $urandom_range(0, gapmax));
    for (int i = 0; i < int'(len); i++) begin
      w = fw[i];
      send(w[15:8], $urandom_range(0, gapmax));
      send(w[7:0], $urandom_range(0, gapmax));
      sum = 8'(sum + w[15:8] + w[7:0]);
    end
    if (CS_EN && len != 0)
      send(bad_cs ? 8'(sum + 8'($urandom_range(1, 255))) : sum, $urandom_range(0, gapmax));
    exp_ok = (len != 0) && !(CS_EN && bad_cs);
    exp_n  = int'(len);
    chk({tag, "_done"},    32'(done), 32'(exp_ok));
    chk({tag, "_error"},   32'(error), 32'(!exp_ok));
    chk({tag, "_cpurst"},  32'(cpu_reset), 32'(!exp_ok));
    chk({tag, "_loading"}, 32'(loading), 32'd0);
    @(negedge clk);
    chk({tag, "_nwrites"}, 32'(got.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < got.size(); i++)
      chk({tag, "_write"}, 32'(got[i]), 32'({12'(i), fw[i]}));
  endtask

  initial begin
    logic [7:0] jb;
    int unsigned len;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset_state("reset");

    // Basic good frame.
    fw.delete();
`ifdef PROG_LOADER_CHECKSUM_EN
    fw.push_back(16'h1234); fw.push_back(16'hABCD);
`else
    fw.push_back(16'hBEEF);
`endif
    run_frame("basic", fw.size(), 4'h0, 1'b0, 0);

    // RUN ignores non-sync bytes; sync restarts loading.
    send(8'h00, 0);
    send(8'h55, 1);
    chk("run_ign_done",   32'(done), 32'd1);
    chk("run_ign_cpurst", 32'(cpu_reset), 32'd0);
    send(8'hA5, 0);
    chk("run_sync_loading", 32'(loading), 32'd1);
    chk("run_sync_cpurst",  32'(cpu_reset), 32'd1);
    chk("run_sync_done",    32'(done), 32'd0);
    do_reset();
    chk_reset_state("rst2");

    // Bad checksum (or plain frame without checksum), then recovery frame.
    fw.delete();
    fw.push_back(16'h1234); fw.push_back(16'hABCD);
    run_frame("badcs", 2, 4'h0, 1'b1, 0);
    fw.delete();
    fw.push_back(16'h0007);
    run_frame("recover", 1, 4'h0, 1'b0, 0);

    // Masked zero length.
    run_frame("len0", 0, 4'hF, 1'b0, 0);

    // Sync byte inside data is just data.
    fw.delete();
    fw.push_back(16'hA5A5);
    run_frame("a5data", 1, 4'hA, 1'b0, 1);

    // Reset mid-frame with gaps, then a stray byte in IDLE.
    do_reset();
    got.delete();
    send(8'hA5, 5);
    send(8'h00, 5);
    send(8'h01, 5);
    repeat (5) @(negedge clk);
    do_reset();
    chk_reset_state("midrst");
    send(8'h12, 0);
    @(negedge clk);
    chk("midrst_nwrites", 32'(got.size()), 32'd0);
    chk("midrst_loading", 32'(loading), 32'd0);
    chk("midrst_cpurst",  32'(cpu_reset), 32'd1);

    // Randomized frames with junk prefixes.
    for (int f = 0; f < 30; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h00;
        send(jb, $urandom_range(0, 2));
      end
      len = $urandom_range(0, 10);
      fw.delete();
      for (int i = 0; i < int'(len); i++)
        fw.push_back(($urandom_range(0, 3) == 0) ? 16'hA5A5 : 16'($urandom));
      run_frame("rand", len, 4'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    // Maximum length frame: addresses 0..4094.
    fw.delete();
    for (int i = 0; i < 4095; i++) fw.push_back(16'($urandom));
    run_frame("maxlen", 4095, 4'h0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
